mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port memory between the processor's instruction-fetch path and its load/store path.
- Each side raises a request. The arbiter grants one request at a time, drives the memory handshake, and routes the response back to the owner.
- Sits between the processor core and the unified memory. It is the block that makes a multi-cycle, stallable memory usable by the core.

Parameters:
- XLEN, 32, address and data width.
- STARVE_LIMIT, 4, number of consecutive load/store grants allowed while a fetch is pending before fetch is forced to win.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held stable until if_gnt.
- if_addr  in  XLEN  fetch address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch data valid, one-cycle pulse.
- if_rdata  out  XLEN  fetch data.
- ls_req  in  1  load/store request; held stable until ls_gnt.
- ls_addr  in  XLEN  data address.
- ls_wdata  in  XLEN  store data.
- ls_wmask  in  4  byte write mask.
- ls_wen  in  1  1 = store, 0 = load.
- ls_gnt  out  1  load/store request accepted.
- ls_rvalid  out  1  load data valid / store acknowledge, one-cycle pulse.
- ls_rdata  out  XLEN  load data.
- mem_valid  out  1  memory request valid.
- mem_ready  in  1  memory accepts request.
- mem_addr, mem_wdata  out  XLEN  latched request fields.
- mem_wmask  out  4  latched request field.
- mem_wen  out  1  latched request field.
- mem_rvalid  in  1  memory response / write acknowledge.
- mem_rdata  in  XLEN  memory read data.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE, owner=OWN_IF, starve_cnt=0, all request registers 0.
  - All outputs 0 while reset is low and immediately after release.
- FSM states: IDLE, REQ, RESP. Only one transaction is outstanding at a time.
- IDLE:
  - If any req is high, arbitrate and latch owner, addr, wdata, wmask and wen into registers.
  - Assert the winner's gnt combinationally in the same cycle, then go to REQ.
  - If no req is high, stay in IDLE; all gnt signals are 0.
  - For a fetch grant, wdata, wmask and wen are latched as 0.
- Arbitration:
  - Load/store has priority.
  - Exception: if if_req and ls_req are both high and starve_cnt==STARVE_LIMIT, fetch wins.
- starve_cnt:
  - +1 on each ls grant while if_req=1, saturating at STARVE_LIMIT.
  - Cleared on any fetch grant.
  - Cleared on an ls grant while if_req=0.
- REQ:
  - mem_valid=1 with the latched fields.
  - On mem_ready=1, go to RESP.
  - mem_rvalid is ignored in REQ; memory must respond at least one cycle after acceptance.
- RESP:
  - mem_valid=0.
  - On mem_rvalid=1, pulse the owner's rvalid in the same cycle, with rdata=mem_rdata, then go to IDLE.
  - Non-owner rvalid stays 0.
- rdata outputs: if_rdata and ls_rdata are mem_rdata gated by their own rvalid; 0 otherwise.
- Minimum latency:
  - gnt at cycle 0, mem_valid at cycle 1; ready at cycle 1 gives earliest rvalid at cycle 2.
  - Back-to-back gnt is possible at cycle 3, since the rvalid cycle itself returns the FSM to IDLE and arbitration happens the following cycle.
- mem_rvalid in IDLE or REQ is ignored. Stale responses after a reset mid-transaction are therefore dropped.
- Requests arriving while busy are not granted. Requesters keep req high until their gnt.
- Writes (mem_wen=1) complete on mem_rvalid; ls_rvalid is the store acknowledge and ls_rdata is don't-care for stores.

Decomposition:
- Package mem_arb_pkg:
  - XLEN default constant.
  - typedef enum logic [1:0] state_t {IDLE, REQ, RESP}.
  - typedef enum logic owner_t {OWN_IF, OWN_LS}.
- Single module; no natural sub-module. The starvation counter is a few lines inline.

Test Plan:
- Reset: hold reset=0 with if_req=1 and mem_rvalid=1 -> all outputs 0; after release, if_gnt=1 next cycle and busy=0 until the gnt cycle ends.
- Single fetch:
  - Stimulus: if_addr=0x8000_0000, mem_ready=1 at cycle 1, mem_rvalid=1 with mem_rdata=0x0000_0013 at cycle 2.
  - Response: mem_addr=0x8000_0000 with mem_valid at cycle 1; if_rvalid=1 and if_rdata=0x13 at cycle 2; ls_rvalid=0.
- Store with backpressure:
  - Stimulus: ls_addr=0x8000_0100, ls_wdata=0xDEAD_BEEF, ls_wmask=4'b0011, ls_wen=1; mem_ready low for 3 cycles.
  - Response: mem_valid held with stable fields for 4 cycles; ls_rvalid pulses once on mem_rvalid.
- Contention and starvation (STARVE_LIMIT=4):
  - Stimulus: if_req and ls_req held continuously.
  - Response: grant order LS, LS, LS, LS, IF, LS, ...; starve_cnt returns to 0 after the IF grant.
- Reset mid-transaction: assert reset in RESP, release, then drive mem_rvalid=1 -> no rvalid on either port; FSM stays in IDLE.
- Spurious response: mem_rvalid=1 in IDLE and in the REQ cycle before mem_ready -> ignored; the later real response is delivered exactly once.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter.
// Holds the default width, FSM state and bus owner encodings.
package mem_arb_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_t;

  typedef enum logic {
    OWN_IF,
    OWN_LS
  } owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between fetch and load/store.
// Ports: if_* fetch side, ls_* load/store side, mem_* memory side,
// clk/reset (async, active-low), busy = transaction in flight.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [XLEN-1:0] if_rdata,
  input  logic            ls_req,
  input  logic [XLEN-1:0] ls_addr,
  input  logic [XLEN-1:0] ls_wdata,
  input  logic [3:0]      ls_wmask,
  input  logic            ls_wen,
  output logic            ls_gnt,
  output logic            ls_rvalid,
  output logic [XLEN-1:0] ls_rdata,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wmask,
  output logic            mem_wen,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            busy
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [CW-1:0]     starve_q, starve_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [3:0]        wmask_q, wmask_d;
  logic              wen_q, wen_d;
  // Low for the first cycle after reset release so no grant
  // can appear before a clock edge has been seen.
  logic              active_q;

  logic idle_ok;
  logic fetch_first;
  logic ls_win;
  logic if_win;
  logic resp_fire;

  always_comb begin
    idle_ok     = active_q && (state_q == IDLE);
    fetch_first = if_req && ls_req && (starve_q == LIMIT);
    ls_win      = idle_ok && ls_req && !fetch_first;
    if_win      = idle_ok && if_req && !ls_win;
    resp_fire   = (state_q == RESP) && mem_rvalid;
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    starve_d = starve_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    wen_d    = wen_q;
    unique case (state_q)
      IDLE: begin
        if (ls_win) begin
          state_d = REQ;
          owner_d = OWN_LS;
          addr_d  = ls_addr;
          wdata_d = ls_wdata;
          wmask_d = ls_wmask;
          wen_d   = ls_wen;
          if (!if_req)
            starve_d = '0;
          else if (starve_q != LIMIT)
            starve_d = starve_q + CW'(1);
        end else if (if_win) begin
          state_d  = REQ;
          owner_d  = OWN_IF;
          addr_d   = if_addr;
          wdata_d  = '0;
          wmask_d  = '0;
          wen_d    = 1'b0;
          starve_d = '0;
        end
      end
      REQ: begin
        if (mem_ready)
          state_d = RESP;
      end
      RESP: begin
        if (mem_rvalid)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      owner_q  <= OWN_IF;
      starve_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      wen_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
      wen_q    <= wen_d;
      active_q <= 1'b1;
    end
  end

  always_comb begin
    if_gnt    = if_win;
    ls_gnt    = ls_win;
    if_rvalid = resp_fire && (owner_q == OWN_IF);
    ls_rvalid = resp_fire && (owner_q == OWN_LS);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    ls_rdata  = ls_rvalid ? mem_rdata : '0;
    mem_valid = (state_q == REQ);
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_wmask = wmask_q;
    mem_wen   = wen_q;
    busy      = (state_q != IDLE);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table,
// directed corner sequences and a randomized reference model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int XLEN = 32;
  localparam int LIM  = 4;

  logic            clk;
  logic            reset;
  logic            if_req;
  logic [XLEN-1:0] if_addr;
  logic            if_gnt;
  logic            if_rvalid;
  logic [XLEN-1:0] if_rdata;
  logic            ls_req;
  logic [XLEN-1:0] ls_addr;
  logic [XLEN-1:0] ls_wdata;
  logic [3:0]      ls_wmask;
  logic            ls_wen;
  logic            ls_gnt;
  logic            ls_rvalid;
  logic [XLEN-1:0] ls_rdata;
  logic            mem_valid;
  logic            mem_ready;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [3:0]      mem_wmask;
  logic            mem_wen;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;
  logic            busy;

  mem_arbiter #(
    .XLEN(XLEN),
    .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk),
    .reset(reset),
    .if_req(if_req),
    .if_addr(if_addr),
    .if_gnt(if_gnt),
    .if_rvalid(if_rvalid),
    .if_rdata(if_rdata),
    .ls_req(ls_req),
    .ls_addr(ls_addr),
    .ls_wdata(ls_wdata),
    .ls_wmask(ls_wmask),
    .ls_wen(ls_wen),
    .ls_gnt(ls_gnt),
    .ls_rvalid(ls_rvalid),
    .ls_rdata(ls_rdata),
    .mem_valid(mem_valid),
    .mem_ready(mem_ready),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask),
    .mem_wen(mem_wen),
    .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [11:0] any_out;
  assign any_out = {if_gnt, if_rvalid, |if_rdata, ls_gnt,
                    ls_rvalid, |ls_rdata, mem_valid, |mem_addr,
                    |mem_wdata, |mem_wmask, mem_wen, busy};

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    if_req     = 1'b0;
    if_addr    = '0;
    ls_req     = 1'b0;
    ls_addr    = '0;
    ls_wdata   = '0;
    ls_wmask   = '0;
    ls_wen     = 1'b0;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
  endtask

  task automatic do_reset();
    quiet();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  // who: 0 none (timeout), 1 fetch, 2 load/store
  task automatic wait_gnt(output int who);
    who = 0;
    for (int c = 0; c < 20 && who == 0; c++) begin
      @(negedge clk);
      if (if_gnt || ls_gnt)
        chk("gnt_excl", 32'(if_gnt & ls_gnt), 32'd0);
      if (if_gnt) who = 1;
      else if (ls_gnt) who = 2;
      tick();
    end
  endtask

  // Called in the REQ cycle: accept, then respond next cycle.
  task automatic complete(input bit is_ls, input logic [31:0] rd);
    mem_ready = 1'b1;
    tick();
    mem_ready  = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = rd;
    @(negedge clk);
    chk("cpl_if_rv", 32'(if_rvalid), 32'(!is_ls));
    chk("cpl_ls_rv", 32'(ls_rvalid), 32'(is_ls));
    tick();
    mem_rvalid = 1'b0;
  endtask

  typedef struct {
    bit          is_ls;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    bit          wen;
    int          rdy_wait;
    int          rsp_wait;
    logic [31:0] rdata;
    logic [31:0] e_wdata;
    logic [3:0]  e_wmask;
    bit          e_wen;
    bit          e_if_rv;
    bit          e_ls_rv;
    logic [31:0] e_if_rd;
    logic [31:0] e_ls_rd;
  } vec_t;

  vec_t vt[4];

  task automatic run_vec(input int i);
    vec_t v;
    v = vt[i];
    if (v.is_ls) begin
      ls_req   = 1'b1;
      ls_addr  = v.addr;
      ls_wdata = v.wdata;
      ls_wmask = v.wmask;
      ls_wen   = v.wen;
    end else begin
      if_req   = 1'b1;
      if_addr  = v.addr;
      ls_wdata = v.wdata;
      ls_wmask = v.wmask;
      ls_wen   = v.wen;
    end
    @(negedge clk);
    chk($sformatf("v%0d_if_gnt", i), 32'(if_gnt), 32'(!v.is_ls));
    chk($sformatf("v%0d_ls_gnt", i), 32'(ls_gnt), 32'(v.is_ls));
    chk($sformatf("v%0d_busy0", i), 32'(busy), 32'd0);
    tick();
    if_req = 1'b0;
    ls_req = 1'b0;
    for (int w = 0; w <= v.rdy_wait; w++) begin
      mem_ready = (w == v.rdy_wait);
      @(negedge clk);
      chk($sformatf("v%0d_mvalid", i), 32'(mem_valid), 32'd1);
      chk($sformatf("v%0d_maddr", i), mem_addr, v.addr);
      chk($sformatf("v%0d_mwdata", i), mem_wdata, v.e_wdata);
      chk($sformatf("v%0d_mwmask", i), 32'(mem_wmask), 32'(v.e_wmask));
      chk($sformatf("v%0d_mwen", i), 32'(mem_wen), 32'(v.e_wen));
      tick();
    end
    mem_ready = 1'b0;
    for (int w = 0; w <= v.rsp_wait; w++) begin
      mem_rvalid = (w == v.rsp_wait);
      mem_rdata  = v.rdata;
      @(negedge clk);
      chk($sformatf("v%0d_rsp_mvalid", i), 32'(mem_valid), 32'd0);
      if (w == v.rsp_wait) begin
        chk($sformatf("v%0d_if_rv", i), 32'(if_rvalid), 32'(v.e_if_rv));
        chk($sformatf("v%0d_ls_rv", i), 32'(ls_rvalid), 32'(v.e_ls_rv));
        chk($sformatf("v%0d_if_rd", i), if_rdata, v.e_if_rd);
        chk($sformatf("v%0d_ls_rd", i), ls_rdata, v.e_ls_rd);
      end else begin
        chk($sformatf("v%0d_early_rv", i),
            32'(if_rvalid | ls_rvalid), 32'd0);
      end
      tick();
    end
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_done_busy", i), 32'(busy), 32'd0);
    tick();
  endtask

  initial begin
    int who;
    int pulses;
    int ifpulses;
    bit ifp, lsp;
    logic [31:0] ia, la, lw;
    logic [3:0] lm;
    bit lwen;
    int ph;
    bit t_ls;
    logic [31:0] t_addr, t_wdata;
    logic [3:0] t_wmask;
    bit t_wen;
    int starve;
    bit wi, wl;

    vt[0] = '{0, 32'h8000_0000, 32'hFFFF_FFFF, 4'hF, 1, 0, 0,
              32'h0000_0013, 32'h0, 4'h0, 0, 1, 0,
              32'h0000_0013, 32'h0};
    vt[1] = '{1, 32'h8000_0100, 32'hDEAD_BEEF, 4'b0011, 1, 3, 1,
              32'h1234_5678, 32'hDEAD_BEEF, 4'b0011, 1, 0, 1,
              32'h0, 32'h1234_5678};
    vt[2] = '{1, 32'h0000_0044, 32'hAAAA_5555, 4'hF, 0, 1, 2,
              32'hCAFE_F00D, 32'hAAAA_5555, 4'hF, 0, 0, 1,
              32'h0, 32'hCAFE_F00D};
    vt[3] = '{0, 32'h0000_1000, 32'h0, 4'h0, 0, 2, 0,
              32'h0050_0093, 32'h0, 4'h0, 0, 1, 0,
              32'h0050_0093, 32'h0};

    // Reset holds everything quiet even with live inputs.
    quiet();
    reset      = 1'b0;
    if_req     = 1'b1;
    if_addr    = 32'h44;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("rst_outs_a", 32'(any_out), 32'd0);
    tick();
    @(negedge clk);
    chk("rst_outs_b", 32'(any_out), 32'd0);
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("rel_outs", 32'(any_out), 32'd0);
    tick();
    @(negedge clk);
    chk("rel_if_gnt", 32'(if_gnt), 32'd1);
    chk("rel_busy", 32'(busy), 32'd0);
    tick();
    if_req     = 1'b0;
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("rel_busy1", 32'(busy), 32'd1);
    chk("rel_maddr", mem_addr, 32'h44);
    tick();
    complete(1'b0, 32'h1);

    // Table-driven single transactions.
    for (int i = 0; i < 4; i++)
      run_vec(i);

    // Continuous contention: four LS grants then one fetch.
    do_reset();
    if_req  = 1'b1;
    if_addr = 32'h100;
    ls_req  = 1'b1;
    ls_addr = 32'h200;
    for (int g = 0; g < 10; g++) begin
      wait_gnt(who);
      chk($sformatf("order%0d", g), 32'(who),
          (g % 5 == 4) ? 32'd1 : 32'd2);
      complete(who == 2, 32'(g));
    end
    if_req = 1'b0;
    ls_req = 1'b0;
    tick();

    // Reset while waiting for the response drops it.
    if_req = 1'b1;
    wait_gnt(who);
    chk("mid_gnt", 32'(who), 32'd1);
    if_req    = 1'b0;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    reset     = 1'b0;
    #1;
    chk("mid_rst_outs", 32'(any_out), 32'd0);
    tick();
    reset      = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h7777_7777;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("mid_no_rv", 32'(if_rvalid | ls_rvalid), 32'd0);
      chk("mid_idle", 32'(busy), 32'd0);
      tick();
    end
    mem_rvalid = 1'b0;

    // Spurious responses in IDLE and REQ are ignored.
    mem_rvalid = 1'b1;
    @(negedge clk);
    chk("sp_idle_rv", 32'(if_rvalid | ls_rvalid), 32'd0);
    tick();
    ls_req  = 1'b1;
    ls_addr = 32'h300;
    ls_wen  = 1'b0;
    @(negedge clk);
    chk("sp_gnt", 32'(ls_gnt), 32'd1);
    chk("sp_gnt_rv", 32'(ls_rvalid), 32'd0);
    tick();
    ls_req = 1'b0;
    @(negedge clk);
    chk("sp_req_rv", 32'(ls_rvalid), 32'd0);
    chk("sp_req_mv", 32'(mem_valid), 32'd1);
    tick();
    mem_ready = 1'b1;
    @(negedge clk);
    chk("sp_acc_rv", 32'(ls_rvalid), 32'd0);
    tick();
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("sp_resp_wait", 32'(ls_rvalid), 32'd0);
    chk("sp_resp_busy", 32'(busy), 32'd1);
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h5A5A_5A5A;
    pulses   = 0;
    ifpulses = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (ls_rvalid) begin
        pulses++;
        chk("sp_rdata", ls_rdata, 32'h5A5A_5A5A);
      end
      if (if_rvalid) ifpulses++;
      tick();
    end
    mem_rvalid = 1'b0;
    chk("sp_once", 32'(pulses), 32'd1);
    chk("sp_if_none", 32'(ifpulses), 32'd0);

    // Randomized traffic against a transaction-level model.
    do_reset();
    ifp = 0;
    lsp = 0;
    ia = '0; la = '0; lw = '0; lm = '0; lwen = 0;
    ph = 0;
    starve = 0;
    t_ls = 0; t_addr = '0; t_wdata = '0; t_wmask = '0; t_wen = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!ifp && $urandom_range(0, 2) == 0) begin
        ifp = 1;
        ia  = $urandom;
      end
      if (!lsp && $urandom_range(0, 2) != 0) begin
        lsp  = 1;
        la   = $urandom;
        lw   = $urandom;
        lm   = 4'($urandom);
        lwen = 1'($urandom);
      end
      if_req   = ifp;
      if_addr  = ia;
      ls_req   = lsp;
      ls_addr  = la;
      ls_wdata = lw;
      ls_wmask = lm;
      ls_wen   = lwen;
      mem_ready  = 1'($urandom);
      mem_rvalid = (ph == 2) ? 1'($urandom)
                             : ($urandom_range(0, 3) == 0);
      mem_rdata  = $urandom;
      @(negedge clk);
      wi = 0;
      wl = 0;
      if (ph == 0) begin
        wi = ifp && (!lsp || starve == LIM);
        wl = lsp && !wi;
      end
      chk("r_if_gnt", 32'(if_gnt), 32'(wi));
      chk("r_ls_gnt", 32'(ls_gnt), 32'(wl));
      chk("r_busy", 32'(busy), 32'(ph != 0));
      chk("r_mvalid", 32'(mem_valid), 32'(ph == 1));
      if (ph == 1) begin
        chk("r_maddr", mem_addr, t_addr);
        chk("r_mwdata", mem_wdata, t_wdata);
        chk("r_mwmask", 32'(mem_wmask), 32'(t_wmask));
        chk("r_mwen", 32'(mem_wen), 32'(t_wen));
      end
      if (ph == 2 && mem_rvalid) begin
        chk("r_if_rv", 32'(if_rvalid), 32'(!t_ls));
        chk("r_ls_rv", 32'(ls_rvalid), 32'(t_ls));
        chk("r_if_rd", if_rdata, t_ls ? 32'h0 : mem_rdata);
        chk("r_ls_rd", ls_rdata, t_ls ? mem_rdata : 32'h0);
      end else begin
        chk("r_no_rv", 32'(if_rvalid | ls_rvalid), 32'd0);
        chk("r_no_rd", if_rdata | ls_rdata, 32'h0);
      end
      case (ph)
        0: begin
          if (wl) begin
            ph = 1;
            t_ls = 1; t_addr = la; t_wdata = lw;
            t_wmask = lm; t_wen = lwen;
            starve = ifp ? ((starve < LIM) ? starve + 1 : LIM) : 0;
            lsp = 0;
          end else if (wi) begin
            ph = 1;
            t_ls = 0; t_addr = ia; t_wdata = '0;
            t_wmask = '0; t_wen = 0;
            starve = 0;
            ifp = 0;
          end
        end
        1: if (mem_ready) ph = 2;
        default: if (mem_rvalid) ph = 0;
      endcase
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
